issue_select: RTL and testbench

- Select/issue controller paired with the scheduler wakeup logic.
- Consumes the per-row request_vector produced by wakeup, tracks the FU type and latency of each allocated scheduler row, and grants at most one ready row per functional unit per cycle using per-FU round-robin.
- Granted rows are issued to the FUs and returned to the free-entry queue.
- Unpipelined FUs are held busy for the instruction latency.

---
 rtl/issue_select.sv | 129 ++++++++++++
 tb/tb_issue_select.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/issue_select.sv
// Select/issue controller: tracks per-row FU/latency metadata and grants at most one
// ready row per functional unit each cycle using a per-FU round-robin pointer.
module issue_select #(
    parameter int                 NUM_ROWS    = 8,
    parameter int                 NUM_FUS     = 4,
    parameter int                 LAT_W       = 8,
    parameter logic [NUM_FUS-1:0] FU_BLOCKING = 4'b1000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_ROWS-1:0]                  request_vector,
    input  logic                                 alloc_en,
    input  logic [$clog2(NUM_ROWS)-1:0]          alloc_row,
    input  logic [$clog2(NUM_FUS)-1:0]           alloc_fu,
    input  logic [LAT_W-1:0]                     alloc_lat,
    input  logic [NUM_FUS-1:0]                   fu_stall,
    input  logic                                 flush,
    output logic [NUM_FUS-1:0]                   issue_valid,
    output logic [NUM_FUS*$clog2(NUM_ROWS)-1:0]  issue_row,
    output logic [NUM_ROWS-1:0]                  free_vector,
    output logic [NUM_FUS-1:0]                   fu_busy,
    output logic                                 alloc_err
);

    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int FU_W  = $clog2(NUM_FUS);

    logic [NUM_ROWS-1:0]        valid;
    logic [FU_W-1:0]            row_fu   [NUM_ROWS];
    logic [LAT_W-1:0]           row_lat  [NUM_ROWS];
    logic [ROW_W-1:0]           rr_ptr   [NUM_FUS];
    logic [LAT_W-1:0]           busy_cnt [NUM_FUS];

    logic [NUM_FUS-1:0]         grant_valid;
    logic [ROW_W-1:0]           grant_row [NUM_FUS];
    logic [NUM_ROWS-1:0]        grant_free;
    logic [NUM_FUS*ROW_W-1:0]   issue_row_next;
    logic [ROW_W-1:0]           cand;
    logic [31:0]                alloc_fu_ext;
    logic                       alloc_bad;

    always_comb begin
        for (int f = 0; f < NUM_FUS; f++) begin
            fu_busy[f] = (busy_cnt[f] != '0);
        end
    end

    // A write is dropped when it targets a live row (including one being granted now).
    assign alloc_fu_ext = 32'(alloc_fu);
    assign alloc_bad    = alloc_en && (valid[alloc_row] || (alloc_fu_ext >= 32'(NUM_FUS)));

    always_comb begin
        grant_valid = '0;
        grant_free  = '0;
        cand        = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            grant_row[f] = '0;
            for (int i = 0; i < NUM_ROWS; i++) begin
                cand = rr_ptr[f] + ROW_W'(i);
                if (!grant_valid[f] && request_vector[cand] && valid[cand] &&
                    (row_fu[cand] == FU_W'(f)) && !fu_stall[f] && !fu_busy[f]) begin
                    grant_valid[f] = 1'b1;
                    grant_row[f]   = cand;
                end
            end
            if (grant_valid[f]) begin
                grant_free[grant_row[f]] = 1'b1;
            end
        end
    end

    always_comb begin
        issue_row_next = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            issue_row_next[f*ROW_W +: ROW_W] = grant_row[f];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            valid       <= '0;
            issue_valid <= '0;
            issue_row   <= '0;
            free_vector <= '0;
            alloc_err   <= 1'b0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                row_fu[r]  <= '0;
                row_lat[r] <= '0;
            end
            for (int f = 0; f < NUM_FUS; f++) begin
                rr_ptr[f]   <= '0;
                busy_cnt[f] <= '0;
            end
        end else begin
            issue_valid <= grant_valid;
            issue_row   <= issue_row_next;
            free_vector <= grant_free;
            alloc_err   <= alloc_bad;

            for (int r = 0; r < NUM_ROWS; r++) begin
                if (grant_free[r]) begin
                    valid[r] <= 1'b0;
                end
            end
            if (alloc_en && !alloc_bad) begin
                valid[alloc_row]   <= 1'b1;
                row_fu[alloc_row]  <= alloc_fu;
                row_lat[alloc_row] <= alloc_lat;
            end

            // Loading lat-1 lets the next grant happen exactly lat cycles later.
            for (int f = 0; f < NUM_FUS; f++) begin
                if (grant_valid[f]) begin
                    rr_ptr[f] <= grant_row[f] + ROW_W'(1);
                end
                if (FU_BLOCKING[f] && grant_valid[f]) begin
                    if (row_lat[grant_row[f]] > LAT_W'(1)) begin
                        busy_cnt[f] <= row_lat[grant_row[f]] - LAT_W'(1);
                    end else begin
                        busy_cnt[f] <= '0;
                    end
                end else if (busy_cnt[f] != '0) begin
                    busy_cnt[f] <= busy_cnt[f] - LAT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_select.sv
// Directed, table-driven bench for issue_select: each record drives one cycle and
// lists the registered outputs expected right after that clock edge.
module tb_issue_select;

    logic        clk;
    logic        rst;
    logic [7:0]  request_vector;
    logic        alloc_en;
    logic [2:0]  alloc_row;
    logic [1:0]  alloc_fu;
    logic [7:0]  alloc_lat;
    logic [3:0]  fu_stall;
    logic        flush;
    logic [3:0]  issue_valid;
    logic [11:0] issue_row;
    logic [7:0]  free_vector;
    logic [3:0]  fu_busy;
    logic        alloc_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic [7:0]  req;
        logic        aen;
        logic [2:0]  arow;
        logic [1:0]  afu;
        logic [7:0]  alat;
        logic [3:0]  stall;
        logic [3:0]  e_iv;
        logic [11:0] e_irow;
        logic [7:0]  e_free;
        logic [3:0]  e_busy;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    issue_select dut (
        .clk            (clk),
        .rst            (rst),
        .request_vector (request_vector),
        .alloc_en       (alloc_en),
        .alloc_row      (alloc_row),
        .alloc_fu       (alloc_fu),
        .alloc_lat      (alloc_lat),
        .fu_stall       (fu_stall),
        .flush          (flush),
        .issue_valid    (issue_valid),
        .issue_row      (issue_row),
        .free_vector    (free_vector),
        .fu_busy        (fu_busy),
        .alloc_err      (alloc_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkVec(input logic r, input logic fl, input logic [7:0] req,
                                   input logic aen, input logic [2:0] arow, input logic [1:0] afu,
                                   input logic [7:0] alat, input logic [3:0] stall,
                                   input logic [3:0] e_iv, input logic [11:0] e_irow,
                                   input logic [7:0] e_free, input logic [3:0] e_busy,
                                   input logic e_err);
        vec_t v;
        v.rst_n = r;    v.flush = fl;     v.req = req;       v.aen = aen;
        v.arow = arow;  v.afu = afu;      v.alat = alat;     v.stall = stall;
        v.e_iv = e_iv;  v.e_irow = e_irow; v.e_free = e_free; v.e_busy = e_busy;
        v.e_err = e_err;
        return v;
    endfunction

    task automatic cmpVal(input string what, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (vec %0d): got %h, expected %h", what, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst            = v.rst_n;
        flush          = v.flush;
        request_vector = v.req;
        alloc_en       = v.aen;
        alloc_row      = v.arow;
        alloc_fu       = v.afu;
        alloc_lat      = v.alat;
        fu_stall       = v.stall;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        cmpVal("issue_valid", idx, 16'(issue_valid), 16'(v.e_iv));
        cmpVal("free_vector", idx, 16'(free_vector), 16'(v.e_free));
        cmpVal("fu_busy",     idx, 16'(fu_busy),     16'(v.e_busy));
        cmpVal("alloc_err",   idx, 16'(alloc_err),   16'(v.e_err));
        for (int f = 0; f < 4; f++) begin
            if (v.e_iv[f]) begin
                cmpVal($sformatf("issue_row[%0d]", f), idx, 16'(issue_row[f*3 +: 3]), 16'(v.e_irow[f*3 +: 3]));
            end
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b0; flush = 1'b0; request_vector = '0; alloc_en = 1'b0;
        alloc_row = '0; alloc_fu = '0; alloc_lat = '0; fu_stall = '0;

        // Reset held for two cycles with arbitrary inputs: everything must read zero.
        for (int k = 0; k < 2; k++) begin
            v = mkVec(1'b0, 1'($urandom), 8'($urandom), 1'b1, 3'($urandom), 2'($urandom),
                      8'($urandom), 4'($urandom), 4'h0, 12'h0, 8'h00, 4'h0, 1'b0);
            applyStimulus(v);
            cmpVal("reset issue_valid", k, 16'(issue_valid), 16'h0);
            cmpVal("reset issue_row",   k, 16'(issue_row),   16'h0);
            cmpVal("reset free_vector", k, 16'(free_vector), 16'h0);
            cmpVal("reset fu_busy",     k, 16'(fu_busy),     16'h0);
            cmpVal("reset alloc_err",   k, 16'(alloc_err),   16'h0);
        end

        // rst, flush, req, aen, arow, afu, alat, stall | iv, {row3,row2,row1,row0}, free, busy, err
        vecs.push_back(mkVec(1,0,8'hFF,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'hFF,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        // single issue
        vecs.push_back(mkVec(1,0,8'h00,1,3,1,1,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h08,0,0,0,0,4'h0, 4'b0010,{3'd0,3'd0,3'd3,3'd0},8'h08,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h08,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        // round robin on fu 0, reallocation of row 0 wraps behind row 5
        vecs.push_back(mkVec(1,0,8'h00,1,0,0,1,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h00,1,2,0,1,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h00,1,5,0,1,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h25,0,0,0,0,4'h0, 4'b0001,{3'd0,3'd0,3'd0,3'd0},8'h01,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h25,0,0,0,0,4'h0, 4'b0001,{3'd0,3'd0,3'd0,3'd2},8'h04,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h25,1,0,0,1,4'h0, 4'b0001,{3'd0,3'd0,3'd0,3'd5},8'h20,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h25,0,0,0,0,4'h0, 4'b0001,{3'd0,3'd0,3'd0,3'd0},8'h01,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h25,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        // blocking fu 3, latency 5
        vecs.push_back(mkVec(1,0,8'h00,1,1,3,5,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h00,1,4,3,5,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h12,0,0,0,0,4'h0, 4'b1000,{3'd1,3'd0,3'd0,3'd0},8'h02,4'h8,0));
        vecs.push_back(mkVec(1,0,8'h12,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h8,0));
        vecs.push_back(mkVec(1,0,8'h12,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h8,0));
        vecs.push_back(mkVec(1,0,8'h12,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h8,0));
        vecs.push_back(mkVec(1,0,8'h12,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h12,0,0,0,0,4'h0, 4'b1000,{3'd4,3'd0,3'd0,3'd0},8'h10,4'h8,0));
        vecs.push_back(mkVec(1,0,8'h00,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h8,0));
        vecs.push_back(mkVec(1,0,8'h00,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h8,0));
        vecs.push_back(mkVec(1,0,8'h00,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h8,0));
        vecs.push_back(mkVec(1,0,8'h00,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        // alloc on the row being granted in the same cycle is rejected
        vecs.push_back(mkVec(1,0,8'h00,1,7,1,1,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h80,1,7,2,3,4'h0, 4'b0010,{3'd0,3'd0,3'd7,3'd0},8'h80,4'h0,1));
        vecs.push_back(mkVec(1,0,8'h80,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        // stall then flush
        vecs.push_back(mkVec(1,0,8'h00,1,6,2,1,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h40,0,0,0,0,4'h4, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h40,0,0,0,0,4'h4, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h40,0,0,0,0,4'h4, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,1,8'h40,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h40,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h40,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        // double alloc keeps the first metadata (fu 1, pipelined)
        vecs.push_back(mkVec(1,0,8'h00,1,2,1,1,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h00,1,2,3,5,4'h0, 4'b0000,12'h0,8'h00,4'h0,1));
        vecs.push_back(mkVec(1,0,8'h04,0,0,0,0,4'h0, 4'b0010,{3'd0,3'd0,3'd2,3'd0},8'h04,4'h0,0));
        // flush beats a bad alloc and clears the pending row
        vecs.push_back(mkVec(1,0,8'h00,1,5,0,1,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,1,8'h00,1,5,0,1,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h20,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        // several FUs issue in the same cycle
        vecs.push_back(mkVec(1,0,8'h00,1,0,0,1,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h00,1,1,1,1,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h00,1,2,2,1,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h00,1,3,0,1,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h0F,0,0,0,0,4'h0, 4'b0111,{3'd0,3'd2,3'd1,3'd0},8'h07,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h0F,0,0,0,0,4'h0, 4'b0001,{3'd0,3'd0,3'd0,3'd3},8'h08,4'h0,0));
        vecs.push_back(mkVec(1,0,8'h0F,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

        // Reset arriving while fu 3 is busy must drop the counter and the row.
        v = mkVec(1,0,8'h00,1,3,3,8'd10,4'h0, 4'b0000,12'h0,8'h00,4'h0,0);
        applyStimulus(v); checkOutput(100, v);
        v = mkVec(1,0,8'h08,0,0,0,0,4'h0, 4'b1000,{3'd3,3'd0,3'd0,3'd0},8'h08,4'h8,0);
        applyStimulus(v); checkOutput(101, v);
        v = mkVec(0,0,8'h08,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h0,0);
        applyStimulus(v); checkOutput(102, v);
        v = mkVec(1,0,8'h08,0,0,0,0,4'h0, 4'b0000,12'h0,8'h00,4'h0,0);
        applyStimulus(v); checkOutput(103, v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
